// File: rtl/boot_loader_if.sv
// Boot-loader bundle: program byte stream in, control-unit requests and bus data out.
interface boot_loader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] boot_data;
    logic                  bootload_address;
    logic                  bootload_ram;
    logic                  cpu_hold;
    logic                  busy;
    logic                  done;

    // Loader side: consumes the stream, drives the bus requests.
    modport slave (
        input  start, in_data, in_valid,
        output in_ready, boot_data, bootload_address, bootload_ram, cpu_hold, busy, done
    );

    // Host side: supplies start and the byte stream, observes the loader.
    modport master (
        output start, in_data, in_valid,
        input  in_ready, boot_data, bootload_address, bootload_ram, cpu_hold, busy, done
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: copies DEPTH program bytes from a valid/ready stream into program RAM via the
// control unit's address and data phases, holding the CPU in reset for the whole load.
module boot_loader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input logic          clk,
    input logic          rst,
    boot_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitByte,
        StAddr,
        StData,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] byte_q, byte_d;

    logic                  in_ready;
    logic [DATA_WIDTH-1:0] boot_data;
    logic                  bootload_address;
    logic                  bootload_ram;
    logic                  cpu_hold;
    logic                  done;

    // State, address and byte registers; reset aborts any load in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
        end
    end

    // Next-state: accept one byte, then an address phase and a data phase per byte.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StWaitByte;
                    addr_d  = '0;
                end
            end
            StWaitByte: begin
                // in_ready is high throughout this state, so valid alone completes the handshake.
                if (bus.in_valid) begin
                    byte_d  = bus.in_data;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                state_d = StData;
            end
            StData: begin
                // Stop at the last address instead of wrapping, even when DEPTH fills the space.
                if (addr_q == LAST_ADDR) begin
                    state_d = StDone;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = StWaitByte;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded purely from registered state so the control unit sees no glitches.
    always_comb begin
        in_ready         = 1'b0;
        boot_data        = '0;
        bootload_address = 1'b0;
        bootload_ram     = 1'b0;
        cpu_hold         = 1'b0;
        done             = 1'b0;
        case (state_q)
            StWaitByte: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            StAddr: begin
                bootload_address = 1'b1;
                boot_data        = DATA_WIDTH'(addr_q);
                cpu_hold         = 1'b1;
            end
            StData: begin
                bootload_ram = 1'b1;
                boot_data    = byte_q;
                cpu_hold     = 1'b1;
            end
            StDone: begin
                done     = 1'b1;
                cpu_hold = 1'b1;
            end
            default: begin
                cpu_hold = 1'b0;
            end
        endcase
    end

    assign bus.in_ready         = in_ready;
    assign bus.boot_data        = boot_data;
    assign bus.bootload_address = bootload_address;
    assign bus.bootload_ram     = bootload_ram;
    assign bus.cpu_hold         = cpu_hold;
    assign bus.busy             = cpu_hold;
    assign bus.done             = done;
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: reset, full load, gapped stream, stray start, mid-load reset,
// and start held across the end of a load.
module tb_boot_loader;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;

    boot_loader_if #(.DATA_WIDTH(8)) bus ();

    boot_loader #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] cur_addr = 8'h00;
    logic [7:0] ram [DEPTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        wr_cnt   = 0;
        done_cnt = 0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'h00;
    endtask

    task automatic verify_ram(input string tag, input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) check_eq(tag, ram[i], 32'(base) + 32'(i));
    endtask

    // Bus monitor: RAM model plus invariants checked every cycle.
    always @(negedge clk) begin
        check_eq("excl_addr_ram", bus.bootload_address & bus.bootload_ram, 0);
        if (!bus.bootload_address && !bus.bootload_ram) check_eq("bd_zero_idle", bus.boot_data, 0);
        check_eq("busy_eq_hold", bus.busy, bus.cpu_hold);
        check_eq("rdy_phase", bus.in_ready & (bus.bootload_address | bus.bootload_ram | bus.done), 0);
        if (bus.done) done_cnt++;
        if (bus.bootload_address) cur_addr = bus.boot_data;
        if (bus.bootload_ram) begin
            check_eq("wr_addr_seq", cur_addr, wr_cnt);
            ram[cur_addr[3:0]] = bus.boot_data;
            wr_cnt++;
        end
    end

    // Run one load of base+i bytes; optional gaps, a stray start during byte poke_idx,
    // or start left high throughout.
    task automatic stream_load(input string tag, input logic [7:0] base, input bit gapped,
                               input int poke_idx, input bit hold_start);
        int idx;
        int gap;
        int cyc;
        bit seen_done;
        bit acc;
        clear_model();
        idx       = 0;
        gap       = gapped ? 2 : 0;
        cyc       = 0;
        seen_done = 1'b0;
        bus.start = 1'b1;
        tick();
        if (!hold_start) bus.start = 1'b0;
        while (!seen_done && cyc < 1000) begin
            if (idx < DEPTH && gap == 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = base + 8'(idx);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                if (gap > 0) gap--;
            end
            if (!hold_start)
                bus.start = (poke_idx >= 0) && bus.bootload_ram &&
                            (bus.boot_data == base + 8'(poke_idx));
            acc = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                gap = gapped ? int'($urandom_range(0, 3)) : 0;
            end
            if (bus.done) seen_done = 1'b1;
        end
        check_eq({tag, "_done_seen"}, seen_done, 1);
        if (!gapped) check_eq({tag, "_cycles"}, cyc, 3 * DEPTH);
        bus.in_valid = 1'b0;
        tick();
        check_eq({tag, "_released"}, {bus.cpu_hold, bus.busy, bus.done}, 0);
        check_eq({tag, "_wr_cnt"}, wr_cnt, DEPTH);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        verify_ram({tag, "_ram"}, base);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        clear_model();

        // Reset: everything low, 0xAA offered in IDLE is never taken.
        tick();
        tick();
        check_eq("rst_outputs",
                 {bus.in_ready, bus.bootload_address, bus.bootload_ram, bus.cpu_hold,
                  bus.busy, bus.done}, 0);
        check_eq("rst_boot_data", bus.boot_data, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_ignore_valid",
                     {bus.in_ready, bus.bootload_address, bus.bootload_ram, bus.busy}, 0);
        end
        check_eq("idle_no_write", wr_cnt, 0);
        bus.in_valid = 1'b0;

        // Full load, valid held high, phase-by-phase checks.
        clear_model();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("full_hold_on", {bus.cpu_hold, bus.busy}, 2'b11);
        for (int n = 0; n < DEPTH; n++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h10 + 8'(n);
            check_eq("full_wait", {bus.in_ready, bus.bootload_address, bus.bootload_ram,
                                   bus.cpu_hold}, 4'b1001);
            tick();
            check_eq("full_addr", {bus.in_ready, bus.bootload_address, bus.bootload_ram,
                                   bus.cpu_hold}, 4'b0101);
            check_eq("full_addr_val", bus.boot_data, n);
            tick();
            check_eq("full_data", {bus.in_ready, bus.bootload_address, bus.bootload_ram,
                                   bus.cpu_hold}, 4'b0011);
            check_eq("full_data_val", bus.boot_data, 32'h10 + 32'(n));
            tick();
        end
        check_eq("full_done", {bus.done, bus.cpu_hold, bus.busy, bus.in_ready}, 4'b1110);
        bus.in_valid = 1'b0;
        tick();
        check_eq("full_idle", {bus.done, bus.cpu_hold, bus.busy, bus.in_ready}, 0);
        check_eq("full_wr_cnt", wr_cnt, DEPTH);
        check_eq("full_done_cnt", done_cnt, 1);
        verify_ram("full_ram", 8'h10);

        // Gapped stream.
        stream_load("gap", 8'h20, 1'b1, -1, 1'b0);

        // Start pulsed during byte 7 data phase.
        stream_load("poke", 8'h30, 1'b0, 7, 1'b0);

        // Reset after byte 5 data phase, then reload from address 0.
        clear_model();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h60 + 8'(wr_cnt);
            if (bus.bootload_ram && bus.boot_data == 8'h65) found = 1'b1;
            else tick();
        end
        check_eq("abort_reached_b5", found, 1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("abort_outputs",
                 {bus.in_ready, bus.bootload_address, bus.bootload_ram, bus.cpu_hold,
                  bus.busy, bus.done}, 0);
        check_eq("abort_boot_data", bus.boot_data, 0);
        bus.in_valid = 1'b0;
        tick();
        check_eq("abort_wr_cnt", wr_cnt, 6);
        rst = 1'b0;
        tick();
        check_eq("abort_idle", {bus.cpu_hold, bus.in_ready}, 0);
        stream_load("reload", 8'h70, 1'b0, -1, 1'b0);

        // Start held high across the end: re-triggers one cycle after returning to IDLE.
        stream_load("hold", 8'h50, 1'b0, -1, 1'b1);
        tick();
        check_eq("retrigger", {bus.busy, bus.in_ready}, 2'b11);
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
